// File: rtl/lru_way_decoder.sv
// 4-way way-index decoder with per-set true-LRU ages.
// Produces a registered one-hot way-enable and answers victim queries.
module lru_way_decoder #(
    parameter int SET_BITS = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                acc_valid,
    output logic                acc_ready,
    input  logic [SET_BITS-1:0] acc_set,
    input  logic [1:0]          acc_way,
    output logic [3:0]          way_en,
    output logic                way_en_valid,
    input  logic                vic_req,
    input  logic [SET_BITS-1:0] vic_set,
    output logic                vic_valid,
    output logic [1:0]          vic_way,
    output logic [3:0]          vic_onehot
);

    localparam int NSETS = 1 << SET_BITS;

    typedef enum logic {
        IDLE,
        UPDATE
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [SET_BITS-1:0] lat_set;
    logic [1:0]          lat_way;
    logic                accept;
    logic [1:0]          age     [NSETS][4];
    logic [1:0]          age_nxt [NSETS][4];
    logic [1:0]          vic_sel;

    function automatic logic [3:0] onehot(input logic [1:0] w);
        logic [3:0] r;
        r = 4'b0000;
        unique case (w)
            2'd0: r = 4'b0001;
            2'd1: r = 4'b0010;
            2'd2: r = 4'b0100;
            default: r = 4'b1000;
        endcase
        return r;
    endfunction

    always_comb begin
        state_nxt = state;
        acc_ready = 1'b0;
        accept    = 1'b0;
        unique case (state)
            IDLE: begin
                acc_ready = 1'b1;
                if (acc_valid) begin
                    accept    = 1'b1;
                    state_nxt = UPDATE;
                end
            end
            UPDATE: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Post-update ages; victim lookup reads these so a same-set query bypasses.
    always_comb begin
        age_nxt = age;
        if (state == UPDATE) begin
            for (int s = 0; s < NSETS; s++) begin
                if (SET_BITS'(s) == lat_set) begin
                    for (int v = 0; v < 4; v++) begin
                        if (2'(v) == lat_way) begin
                            age_nxt[s][v] = 2'd0;
                        end else if (age[s][v] < age[s][lat_way]) begin
                            age_nxt[s][v] = age[s][v] + 2'd1;
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        vic_sel = 2'd0;
        for (int w = 0; w < 4; w++) begin
            if (age_nxt[vic_set][w] == 2'd3) begin
                vic_sel = 2'(w);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            lat_set      <= '0;
            lat_way      <= 2'd0;
            way_en       <= 4'b0000;
            way_en_valid <= 1'b0;
            vic_valid    <= 1'b0;
            vic_way      <= 2'd0;
            vic_onehot   <= 4'b0000;
            for (int s = 0; s < NSETS; s++) begin
                for (int w = 0; w < 4; w++) begin
                    age[s][w] <= 2'(w);
                end
            end
        end else begin
            state        <= state_nxt;
            age          <= age_nxt;
            way_en_valid <= accept;
            way_en       <= accept ? onehot(acc_way) : 4'b0000;
            if (accept) begin
                lat_set <= acc_set;
                lat_way <= acc_way;
            end
            vic_valid <= vic_req;
            if (vic_req) begin
                vic_way    <= vic_sel;
                vic_onehot <= onehot(vic_sel);
            end
        end
    end

endmodule

// File: tb/tb_lru_way_decoder.sv
// Bench for lru_way_decoder: recency-list model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_lru_way_decoder;

    localparam int SET_BITS = 2;
    localparam int NSETS = 1 << SET_BITS;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic                acc_valid = 1'b0;
    logic                acc_ready;
    logic [SET_BITS-1:0] acc_set = '0;
    logic [1:0]          acc_way = 2'd0;
    logic [3:0]          way_en;
    logic                way_en_valid;
    logic                vic_req = 1'b0;
    logic [SET_BITS-1:0] vic_set = '0;
    logic                vic_valid;
    logic [1:0]          vic_way;
    logic [3:0]          vic_onehot;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    lru_way_decoder #(.SET_BITS(SET_BITS)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .acc_valid    (acc_valid),
        .acc_ready    (acc_ready),
        .acc_set      (acc_set),
        .acc_way      (acc_way),
        .way_en       (way_en),
        .way_en_valid (way_en_valid),
        .vic_req      (vic_req),
        .vic_set      (vic_set),
        .vic_valid    (vic_valid),
        .vic_way      (vic_way),
        .vic_onehot   (vic_onehot)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each set is a recency list, MRU first, LRU last.
    int unsigned order [NSETS][$];
    bit          m_busy;
    int unsigned m_set;
    int unsigned m_way;
    logic        e_wev;
    logic [3:0]  e_we;
    logic        e_vv;
    logic [1:0]  e_vw;
    logic [3:0]  e_voh;

    function automatic void model_init();
        for (int s = 0; s < NSETS; s++) begin
            order[s] = {};
            for (int w = 0; w < 4; w++) order[s].push_back(w);
        end
        m_busy = 0;
        m_set = 0;
        m_way = 0;
        e_wev = 0;
        e_we = 4'b0000;
        e_vv = 0;
        e_vw = 2'd0;
        e_voh = 4'b0000;
    endfunction

    function automatic void touch(input int unsigned s, input int unsigned w);
        for (int i = 0; i < order[s].size(); i++) begin
            if (order[s][i] == w) begin
                order[s].delete(i);
                break;
            end
        end
        order[s].push_front(w);
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            model_init();
        end else begin
            if (m_busy) begin
                touch(m_set, m_way);
                m_busy = 0;
                e_wev = 0;
                e_we = 4'b0000;
            end else if (acc_valid) begin
                m_busy = 1;
                m_set = acc_set;
                m_way = acc_way;
                e_wev = 1;
                e_we = 4'b0001 << acc_way;
            end else begin
                e_wev = 0;
                e_we = 4'b0000;
            end
            e_vv = vic_req;
            if (vic_req) begin
                e_vw = 2'(order[vic_set][3]);
                e_voh = 4'b0001 << e_vw;
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            logic [3:0] seen;
            check("acc_ready", acc_ready, !m_busy);
            check("way_en_valid", way_en_valid, e_wev);
            check("way_en", way_en, e_we);
            check("vic_valid", vic_valid, e_vv);
            check("vic_way", vic_way, e_vw);
            check("vic_onehot", vic_onehot, e_voh);
            for (int s = 0; s < NSETS; s++) begin
                seen = 4'b0000;
                for (int w = 0; w < 4; w++) seen[dut.age[s][w]] = 1'b1;
                check("age_perm", seen, 4'hf);
                assert (seen == 4'hf);
            end
        end
    end

    task automatic access(input int s, input int w);
        acc_valid = 1'b1;
        acc_set = SET_BITS'(s);
        acc_way = 2'(w);
        @(negedge clk);
        acc_valid = 1'b0;
    endtask

    task automatic query(input int s);
        vic_req = 1'b1;
        vic_set = SET_BITS'(s);
        @(negedge clk);
        vic_req = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 reset_n = 1'b0;
        #3 reset_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int pulses;
        repeat (2) @(negedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);

        // Reset state and first query
        check("rst_acc_ready", acc_ready, 1);
        check("rst_way_en", way_en, 4'b0000);
        query(0);
        check("q0_valid", vic_valid, 1);
        check("q0_way", vic_way, 3);
        check("q0_onehot", vic_onehot, 4'b1000);
        @(negedge clk);
        check("q0_pulse", vic_valid, 0);

        // Single access set 1 way 2
        access(1, 2);
        check("a12_ready", acc_ready, 0);
        check("a12_way_en", way_en, 4'b0100);
        check("a12_wev", way_en_valid, 1);
        @(negedge clk);
        check("s1_age0", dut.age[1][0], 1);
        check("s1_age1", dut.age[1][1], 2);
        check("s1_age2", dut.age[1][2], 0);
        check("s1_age3", dut.age[1][3], 3);
        check("s1_model_lru", order[1][3], 3);
        check("s1_model_mru", order[1][0], 2);

        // Ways 3,0,1,2 on set 0, then query; then touch 3 and query
        access(0, 3); @(negedge clk);
        access(0, 0); @(negedge clk);
        access(0, 1); @(negedge clk);
        access(0, 2); @(negedge clk);
        query(0);
        check("seq_way", vic_way, 3);
        check("seq_onehot", vic_onehot, 4'b1000);
        access(0, 3); @(negedge clk);
        query(0);
        check("seq3_way", vic_way, 0);
        check("seq3_onehot", vic_onehot, 4'b0001);

        // Continuous acc_valid on set 2 way 1
        acc_valid = 1'b1;
        acc_set = 2'd2;
        acc_way = 2'd1;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (way_en_valid) pulses++;
            check("stream_wev", way_en_valid, (i % 2 == 0) ? 1 : 0);
        end
        acc_valid = 1'b0;
        check("stream_pulses", pulses, 4);
        @(negedge clk);
        check("s2_age0", dut.age[2][0], 1);
        check("s2_age1", dut.age[2][1], 0);
        check("s2_age2", dut.age[2][2], 2);
        check("s2_age3", dut.age[2][3], 3);

        // Bypass: query the set being updated in the UPDATE cycle
        do_reset();
        access(0, 3);
        vic_req = 1'b1;
        vic_set = 2'd0;
        @(negedge clk);
        vic_req = 1'b0;
        check("byp_way", vic_way, 2);
        check("byp_onehot", vic_onehot, 4'b0100);
        access(0, 1);
        vic_req = 1'b1;
        vic_set = 2'd1;
        @(negedge clk);
        vic_req = 1'b0;
        check("other_set_way", vic_way, 3);

        // Reset in the middle of an update
        @(negedge clk);
        access(1, 0);
        check("pre_rst_wev", way_en_valid, 1);
        #1 reset_n = 1'b0;
        #1;
        check("mid_rst_wev", way_en_valid, 0);
        check("mid_rst_ready", acc_ready, 1);
        check("mid_rst_vv", vic_valid, 0);
        #2 reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", acc_ready, 1);
        for (int s = 0; s < NSETS; s++) begin
            query(s);
            check("post_rst_way", vic_way, 3);
        end
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
